// File: rtl/morse_lookup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : morse_lookup_ctrl
// Description : Sequencer between the Morse symbol classifier and a 256x8
//               synchronous Morse-to-ASCII lookup ROM. Dot/dash pulses are
//               packed into a code. On a letter or word boundary the code
//               becomes the ROM address. The looked-up byte, plus a trailing
//               space after each word, is then offered to the consumer over
//               a valid/ready handshake.
// Ports       : clk          - system clock, rising edge
//               reset_n      - synchronous active-low reset
//               dot_in       - one-cycle pulse, dot symbol
//               dash_in      - one-cycle pulse, dash symbol
//               letter_end   - one-cycle pulse, inter-letter gap
//               word_end     - one-cycle pulse, inter-word gap (implies letter end)
//               rom_addr     - registered ROM address {len[2:0], pat[4:0]}
//               rom_data     - ROM read data, one cycle after rom_addr sampled
//               ascii        - character to consumer
//               ascii_valid  - ascii holds a character
//               ascii_ready  - consumer accepts when valid & ready
//               sym_overflow - pulse: symbol received with a full letter
//               char_dropped - pulse: boundary arrived outside COLLECT
// Revision    : 1.0 - initial release
// ============================================================================
module morse_lookup_ctrl #(
  parameter int         MAX_SYMS = 5,
  parameter logic [7:0] ERR_CHAR = 8'h3F
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dot_in,
  input  logic       dash_in,
  input  logic       letter_end,
  input  logic       word_end,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] ascii,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic       sym_overflow,
  output logic       char_dropped
);

  localparam logic [2:0] c_MAX_LEN = 3'(MAX_SYMS);
  localparam logic [7:0] c_SPACE   = 8'h20;

  typedef enum logic [2:0] {
    S_COLLECT = 3'd0,
    S_READ    = 3'd1,
    S_WAIT    = 3'd2,
    S_HOLD    = 3'd3,
    S_SPACE   = 3'd4
  } state_t;

  state_t     r_state;
  logic [2:0] r_len;
  logic [4:0] r_pat;
  logic       r_err;
  logic       r_err_q;
  logic       r_space_pend;
  logic [7:0] r_rom_addr;
  logic [7:0] r_ascii;
  logic       r_ascii_valid;
  logic       r_sym_overflow;
  logic       r_char_dropped;

  logic       w_sym_valid;
  logic       w_boundary;
  logic [2:0] w_len_nxt;
  logic [4:0] w_pat_nxt;
  logic       w_err_nxt;
  logic       w_ovf;

  // Simultaneous dot and dash is ambiguous and is dropped.
  assign w_sym_valid = dot_in ^ dash_in;
  assign w_boundary  = letter_end | word_end;

  // Accumulator with this cycle's symbol folded in, so a symbol arriving with
  // a boundary still belongs to the letter being closed.
  always_comb begin
    w_len_nxt = r_len;
    w_pat_nxt = r_pat;
    w_err_nxt = r_err;
    w_ovf     = 1'b0;
    if (w_sym_valid) begin
      if (r_len == c_MAX_LEN) begin
        w_err_nxt = 1'b1;
        w_ovf     = 1'b1;
      end else begin
        w_len_nxt = r_len + 3'd1;
        w_pat_nxt = {r_pat[3:0], dash_in};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= S_COLLECT;
      r_len          <= 3'd0;
      r_pat          <= 5'd0;
      r_err          <= 1'b0;
      r_err_q        <= 1'b0;
      r_space_pend   <= 1'b0;
      r_rom_addr     <= 8'd0;
      r_ascii        <= 8'd0;
      r_ascii_valid  <= 1'b0;
      r_sym_overflow <= 1'b0;
      r_char_dropped <= 1'b0;
    end else begin
      r_len          <= w_len_nxt;
      r_pat          <= w_pat_nxt;
      r_err          <= w_err_nxt;
      r_sym_overflow <= w_ovf;
      r_char_dropped <= 1'b0;

      case (r_state)
        S_COLLECT: begin
          if (w_boundary) begin
            if (w_len_nxt != 3'd0) begin
              r_rom_addr   <= {w_len_nxt, w_pat_nxt};
              r_err_q      <= w_err_nxt;
              r_space_pend <= word_end;
              r_len        <= 3'd0;
              r_pat        <= 5'd0;
              r_err        <= 1'b0;
              r_state      <= S_READ;
            end else if (word_end) begin
              r_state <= S_SPACE;
            end
          end
        end
        // ROM samples rom_addr on this edge; its data is valid in WAIT.
        S_READ: r_state <= S_WAIT;
        S_WAIT: begin
          r_ascii       <= r_err_q ? ERR_CHAR : rom_data;
          r_ascii_valid <= 1'b1;
          r_state       <= S_HOLD;
        end
        S_HOLD: begin
          if (r_ascii_valid && ascii_ready) begin
            r_ascii_valid <= 1'b0;
            r_state       <= r_space_pend ? S_SPACE : S_COLLECT;
          end
        end
        S_SPACE: begin
          r_ascii       <= c_SPACE;
          r_ascii_valid <= 1'b1;
          r_space_pend  <= 1'b0;
          r_state       <= S_HOLD;
        end
        default: r_state <= S_COLLECT;
      endcase

      // A boundary while busy throws away the letter collected so far.
      if ((r_state != S_COLLECT) && w_boundary) begin
        r_char_dropped <= 1'b1;
        r_len          <= 3'd0;
        r_pat          <= 5'd0;
        r_err          <= 1'b0;
      end
    end
  end

  assign rom_addr     = r_rom_addr;
  assign ascii        = r_ascii;
  assign ascii_valid  = r_ascii_valid;
  assign sym_overflow = r_sym_overflow;
  assign char_dropped = r_char_dropped;

endmodule
`default_nettype wire

// File: tb/tb_morse_lookup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_lookup_ctrl
// Description : Directed self-checking bench for morse_lookup_ctrl with a
//               registered lookup ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_lookup_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       dot_in, dash_in, letter_end, word_end;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] ascii;
  logic       ascii_valid;
  logic       ascii_ready;
  logic       sym_overflow;
  logic       char_dropped;

  int n_checks = 0;
  int n_pass   = 0;

  morse_lookup_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dot_in       (dot_in),
    .dash_in      (dash_in),
    .letter_end   (letter_end),
    .word_end     (word_end),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .ascii        (ascii),
    .ascii_valid  (ascii_valid),
    .ascii_ready  (ascii_ready),
    .sym_overflow (sym_overflow),
    .char_dropped (char_dropped)
  );

  always #5 clk = ~clk;

  // Lookup ROM: a few real entries, everything else reads as the inverted
  // address so a bad address or error substitution is visible.
  function automatic logic [7:0] rom_f(input logic [7:0] a);
    case (a)
      8'h20:   rom_f = 8'h45;  // E
      8'h21:   rom_f = 8'h54;  // T
      8'h41:   rom_f = 8'h41;  // A
      8'h42:   rom_f = 8'h4E;  // N
      8'h67:   rom_f = 8'h4F;  // O
      default: rom_f = ~a;
    endcase
  endfunction

  always_ff @(posedge clk) rom_data <= rom_f(rom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic dot();
    dot_in = 1'b1; tick(); dot_in = 1'b0;
  endtask

  task automatic dash();
    dash_in = 1'b1; tick(); dash_in = 1'b0;
  endtask

  task automatic lend();
    letter_end = 1'b1; tick(); letter_end = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; dot_in = 1'b0; dash_in = 1'b0;
    letter_end = 1'b0; word_end = 1'b0; ascii_ready = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    chk("rst_addr", rom_addr, 8'h00);
    chk("rst_ascii", ascii, 8'h00);
    chk("rst_valid", ascii_valid, 1'b0);
    chk("rst_ovf", sym_overflow, 1'b0);
    chk("rst_drop", char_dropped, 1'b0);

    // A: dot dash, ready high
    dot(); dash(); lend();
    chk("A_addr", rom_addr, 8'h41);
    chk("A_valid_n1", ascii_valid, 1'b0);
    tick();
    chk("A_valid_n2", ascii_valid, 1'b0);
    tick();
    chk("A_valid", ascii_valid, 1'b1);
    chk("A_ascii", ascii, 8'h41);
    tick();
    chk("A_valid_drop", ascii_valid, 1'b0);

    // O + word_end, consumer stalls 4 cycles
    ascii_ready = 1'b0;
    dash(); dash(); dash();
    word_end = 1'b1; tick(); word_end = 1'b0;
    chk("O_addr", rom_addr, 8'h67);
    tick(); tick();
    chk("O_valid", ascii_valid, 1'b1);
    chk("O_ascii", ascii, 8'h4F);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("O_hold_valid", ascii_valid, 1'b1);
      chk("O_hold_ascii", ascii, 8'h4F);
    end
    ascii_ready = 1'b1;
    tick();
    chk("O_gap", ascii_valid, 1'b0);
    tick();
    chk("SP_valid", ascii_valid, 1'b1);
    chk("SP_ascii", ascii, 8'h20);
    tick();
    chk("SP_done", ascii_valid, 1'b0);
    tick();
    chk("SP_no_more", ascii_valid, 1'b0);

    // Over-length letter: six dots
    for (int i = 0; i < 5; i++) dot();
    chk("ovf_before", sym_overflow, 1'b0);
    dot();
    chk("ovf_pulse", sym_overflow, 1'b1);
    lend();
    chk("ovf_clear", sym_overflow, 1'b0);
    chk("ovf_addr", rom_addr, 8'hA0);
    tick(); tick();
    chk("ovf_valid", ascii_valid, 1'b1);
    chk("ovf_ascii", ascii, 8'h3F);
    tick();
    chk("ovf_done", ascii_valid, 1'b0);

    // E, then a letter arriving during HOLD is dropped
    ascii_ready = 1'b0;
    dot(); lend();
    chk("E_addr", rom_addr, 8'h20);
    tick(); tick();
    chk("E_ascii", ascii, 8'h45);
    chk("E_valid", ascii_valid, 1'b1);
    dash();
    chk("drop_idle", char_dropped, 1'b0);
    lend();
    chk("drop_pulse", char_dropped, 1'b1);
    chk("drop_addr_kept", rom_addr, 8'h20);
    tick();
    chk("drop_clear", char_dropped, 1'b0);
    chk("E_still", ascii, 8'h45);
    ascii_ready = 1'b1;
    tick();
    chk("E_done", ascii_valid, 1'b0);
    tick();
    chk("E_only_one", ascii_valid, 1'b0);
    dot(); lend();
    chk("E2_addr", rom_addr, 8'h20);
    tick(); tick();
    chk("E2_ascii", ascii, 8'h45);
    tick();

    // Symbol in the same cycle as the boundary; simultaneous dot+dash
    dash();
    dot_in = 1'b1; letter_end = 1'b1; tick(); dot_in = 1'b0; letter_end = 1'b0;
    chk("N_addr", rom_addr, 8'h42);
    tick(); tick();
    chk("N_ascii", ascii, 8'h4E);
    tick();
    dot_in = 1'b1; dash_in = 1'b1; tick(); dot_in = 1'b0; dash_in = 1'b0;
    dot(); lend();
    chk("both_ignored_addr", rom_addr, 8'h20);
    tick(); tick(); tick();

    // Reset in WAIT aborts the letter
    dash(); lend();
    chk("T_addr", rom_addr, 8'h21);
    tick();
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk("mrst_addr", rom_addr, 8'h00);
    chk("mrst_ascii", ascii, 8'h00);
    chk("mrst_valid", ascii_valid, 1'b0);
    tick(); tick();
    chk("mrst_no_char", ascii_valid, 1'b0);

    // Bare word boundary emits a lone space
    word_end = 1'b1; tick(); word_end = 1'b0;
    chk("bare_gap", ascii_valid, 1'b0);
    tick();
    chk("bare_valid", ascii_valid, 1'b1);
    chk("bare_ascii", ascii, 8'h20);
    tick();
    chk("bare_done", ascii_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/morse_lookup_ctrl.md
# morse_lookup_ctrl

Sequencer between the Morse symbol classifier and the 256×8 synchronous Morse-to-ASCII lookup ROM. It accumulates dot/dash pulses into a packed code and, on a letter or word boundary, forms the ROM address. It then waits out the ROM's one-cycle read latency and presents the resulting ASCII byte to the downstream consumer (UART TX / display buffer) over a valid/ready handshake. It also inserts a space (0x20) after each word boundary and flags malformed or dropped letters.

## Interface
- MAX_SYMS, 5, maximum symbols per letter; fixed by the address packing below.
- ERR_CHAR, 8'h3F, byte emitted for an over-length letter.
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- dot_in  in  1  one-cycle pulse: dot symbol.
- dash_in  in  1  one-cycle pulse: dash symbol.
- letter_end  in  1  one-cycle pulse: inter-letter gap detected.
- word_end  in  1  one-cycle pulse: inter-word gap; implies letter_end.
- rom_addr  out  8  registered address to ROM.
- rom_data  in  8  ROM registered read data, valid one cycle after rom_addr is sampled.
- ascii  out  8  character to consumer.
- ascii_valid  out  1  ascii holds a character.
- ascii_ready  in  1  consumer accepts when ascii_valid & ascii_ready.
- sym_overflow  out  1  one-cycle pulse: 6th symbol received in a letter.
- char_dropped  out  1  one-cycle pulse: boundary arrived while the FSM was not in COLLECT.

## Operation
- Accumulator: len[2:0] (0–5), pat[4:0], err flag.
- Symbol: pat <= {pat[3:0], s}, with dot=0 and dash=1; len <= len+1.
  - The first symbol ends up in bit len-1.
- dot_in & dash_in in the same cycle: ignored.
- Symbol with len==5: accumulator unchanged, err <= 1, sym_overflow pulses.
- Address packing: rom_addr = {len, pat}. Examples: E=0x20, T=0x21, A=0x41, O=0x67.
- FSM states: COLLECT, READ, WAIT, HOLD, SPACE.
- COLLECT, boundary (letter_end | word_end):
  - len>0: rom_addr <= {len,pat}; capture err into err_q; space_pend <= word_end; clear accumulator; go to READ.
  - len==0 with word_end: go to SPACE.
  - len==0 with letter_end only: ignored.
  - A symbol in the same cycle as a boundary belongs to the closing letter: it is folded in before packing.
- READ: ROM samples rom_addr; go to WAIT.
- WAIT: ascii <= err_q ? ERR_CHAR : rom_data; ascii_valid <= 1; go to HOLD.
- HOLD: on handshake, ascii_valid <= 0; go to SPACE if space_pend, else COLLECT.
- SPACE: ascii <= 8'h20; ascii_valid <= 1; space_pend <= 0; go to HOLD.
- Outside COLLECT:
  - Symbols continue to accumulate into the cleared accumulator (the next letter).
  - Boundaries are discarded: char_dropped pulses and the accumulator clears.

## Timing
- Reset (reset_n low at an edge) forces state=COLLECT, len/pat/err/space_pend=0, rom_addr=0, ascii=0, ascii_valid=0, sym_overflow=0, char_dropped=0.
- Reset mid-letter or mid-handshake discards everything; no partial output.
- Latency: boundary sampled at edge N → rom_addr valid after N → ROM data after N+1 → ascii_valid high after N+2.
- Space insertion: ascii_valid for the space rises the cycle after the letter handshake, so ascii_valid has one low cycle between them.
- Bare word_end in COLLECT: ascii_valid high after the next edge.
- ascii and ascii_valid are stable while ascii_valid & !ascii_ready. There is no combinational path from ascii_ready to ascii_valid.
- rom_addr holds its value after READ until the next boundary.
- Throughput: at most one character per 3 cycles; back-to-back handshakes are not required.

## Test plan
- dot, dash, letter_end, with ascii_ready=1 → rom_addr=0x41; ascii=rom[0x41] ('A'), ascii_valid for 1 cycle, exactly 2 cycles after letter_end.
- dash ×3, then word_end, with ascii_ready held low 4 cycles → rom_addr=0x67; ascii='O' held stable until ready, then ascii=0x20 one cycle later; both accepted; then back to COLLECT.
- dot ×6, letter_end → sym_overflow pulses on the 6th dot; ascii=0x3F regardless of rom_data.
- dot, letter_end, then in HOLD with ready low: dash, letter_end → char_dropped pulses, the second letter is discarded, only 'E' emitted; a following dot, letter_end yields rom_addr=0x20.
- dot and letter_end in the same cycle, after a prior dash → rom_addr=0x42 ({2, 00010}, dash-dot = 'N'); dot_in & dash_in together → no len change.
- reset_n low for 1 cycle while in WAIT → next cycle all outputs 0, state COLLECT; no character emitted for the aborted letter.
